// File: rtl/qoi_stream_encoder_if.sv
// Pixel-in / byte-out handshake bundle for qoi_stream_encoder.
// The pixel source and byte sink connect through the master modport.
interface qoi_stream_encoder_if;
    logic [7:0] in_r;
    logic [7:0] in_g;
    logic [7:0] in_b;
    logic [7:0] in_a;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output in_r, in_g, in_b, in_a, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_r, in_g, in_b, in_a, in_last, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/qoi_stream_encoder.sv
// Streaming QOI chunk encoder: pixels in over valid/ready, one chunk byte out per cycle.
// Define QOI_END_MARKER_EN to append the 8-byte end marker after each image's last pixel.
module qoi_stream_encoder #(
    parameter int CHANNELS = 4,
    parameter int MAX_RUN  = 62
) (
    input  logic                 clk,
    input  logic                 rst,
    qoi_stream_encoder_if.slave  bus
);
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] a;
    } pixel_t;

    typedef enum logic {ACCEPT, EMIT} state_t;

`ifdef QOI_END_MARKER_EN
    localparam int PTR_W = 4;
`else
    localparam int PTR_W = 3;
`endif
    localparam int     BUF_DEPTH = 1 << PTR_W;
    localparam pixel_t PREV_INIT = {8'h00, 8'h00, 8'h00, 8'hFF};

    state_t             state;
    pixel_t             prev;
    pixel_t             index [64];
    logic [5:0]         run;
    logic [7:0]         buffer [BUF_DEPTH];
    logic [PTR_W-1:0]   len;
    logic [PTR_W-1:0]   rd_ptr;
    logic               img_last;
    logic [7:0]         data_q;
    logic               valid_q;
    logic               last_q;

    pixel_t             px;
    logic [5:0]         hash;
    logic [7:0]         dr, dg, db, dr_dg, db_dg;
    logic [39:0]        chunk;
    int                 chunk_len;
    logic [7:0]         nbuf [BUF_DEPTH];
    logic [PTR_W-1:0]   nlen;
    logic [5:0]         run_next;
    logic               accept;

    // in_ready depends only on state and reset, never on in_valid, so no comb loop with the source.
    assign bus.in_ready  = (state == ACCEPT) && rst;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign accept        = bus.in_ready && bus.in_valid;

    function automatic logic in_range(input logic [7:0] v, input int lo, input int hi);
        return (int'($signed(v)) >= lo) && (int'($signed(v)) <= hi);
    endfunction

    always_comb begin
        px    = {bus.in_r, bus.in_g, bus.in_b, (CHANNELS == 3) ? 8'hFF : bus.in_a};
        hash  = 6'(px.r) * 6'd3 + 6'(px.g) * 6'd5 + 6'(px.b) * 6'd7 + 6'(px.a) * 6'd11;
        dr    = px.r - prev.r;
        dg    = px.g - prev.g;
        db    = px.b - prev.b;
        dr_dg = dr - dg;
        db_dg = db - dg;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        chunk     = '0;
        chunk_len = 0;
        if (index[hash] == px) begin
            chunk     = {2'b00, hash, 32'h0};
            chunk_len = 1;
        end else if (px.a != prev.a) begin
            chunk     = {8'hFF, px.r, px.g, px.b, px.a};
            chunk_len = 5;
        end else if (in_range(dr, -2, 1) && in_range(dg, -2, 1) && in_range(db, -2, 1)) begin
            chunk     = {2'b01, 2'(dr + 8'd2), 2'(dg + 8'd2), 2'(db + 8'd2), 32'h0};
            chunk_len = 1;
        end else if (in_range(dg, -32, 31) && in_range(dr_dg, -8, 7) && in_range(db_dg, -8, 7)) begin
            chunk     = {2'b10, 6'(dg + 8'd32), 4'(dr_dg + 8'd8), 4'(db_dg + 8'd8), 24'h0};
            chunk_len = 2;
        end else begin
            chunk     = {8'hFE, px.r, px.g, px.b, 8'h00};
            chunk_len = 4;
        end
    end

    always_comb begin
        nbuf     = '{default: '0};
        nlen     = '0;
        run_next = run;
        if (px == prev) begin
            if (!bus.in_last && (int'(run) + 1 < MAX_RUN)) begin
                run_next = run + 6'd1;
            end else begin
                nbuf[0]  = {2'b11, run};
                nlen     = PTR_W'(1);
                run_next = '0;
            end
        end else begin
            run_next = '0;
            if (run != '0) begin
                nbuf[0] = {2'b11, run - 6'd1};
                nlen    = PTR_W'(1);
            end
            for (int i = 0; i < 5; i++) begin
                if (i < chunk_len) begin
                    nbuf[nlen] = chunk[39 - 8*i -: 8];
                    nlen       = nlen + 1'b1;
                end
            end
        end
`ifdef QOI_END_MARKER_EN
        if (bus.in_last) begin
            for (int i = 0; i < 8; i++) begin
                nbuf[nlen] = (i == 7) ? 8'h01 : 8'h00;
                nlen       = nlen + 1'b1;
            end
        end
`endif
    end

    // NOTE: the byte buffer needs no reset (always written before it is read); the index
    // table does, because a cleared table is visible through INDEX hits on the next pixel.
    always_ff @(posedge clk) begin
        if (accept) begin
            buffer <= nbuf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ACCEPT;
            prev     <= PREV_INIT;
            run      <= '0;
            len      <= '0;
            rd_ptr   <= '0;
            img_last <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                index[i] <= '0;
            end
        end else begin
            case (state)
                ACCEPT: begin
                    if (bus.in_valid) begin
                        prev        <= px;
                        index[hash] <= px;
                        run         <= run_next;
                        if (nlen != '0) begin
                            state    <= EMIT;
                            len      <= nlen;
                            rd_ptr   <= PTR_W'(1);
                            img_last <= bus.in_last;
                            data_q   <= nbuf[0];
                            valid_q  <= 1'b1;
                            last_q   <= bus.in_last && (nlen == PTR_W'(1));
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (rd_ptr == len) begin
                            state   <= ACCEPT;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            if (img_last) begin
                                prev <= PREV_INIT;
                                run  <= '0;
                                for (int i = 0; i < 64; i++) begin
                                    index[i] <= '0;
                                end
                            end
                        end else begin
                            data_q <= buffer[rd_ptr];
                            last_q <= img_last && ((rd_ptr + 1'b1) == len);
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                default: state <= ACCEPT;
            endcase
        end
    end
endmodule
